// File: rtl/packetizer_s2mm_v2_if.sv
// rtl/packetizer_s2mm_v2_if.sv - AXI-Stream-like beat interface carrying tlast/tuser framing
interface packetizer_s2mm_v2_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic                  tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/packetizer_s2mm_v2.sv
// rtl/packetizer_s2mm_v2.sv - cuts a sample stream into fixed-length packets for the S2MM DMA
// Marks first/last beat, supports one-shot runs and applies config changes only at packet boundaries.
module packetizer_s2mm_v2 #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32,
    parameter int PKT_WIDTH  = 32
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    packetizer_s2mm_v2_if.slave  s_axis_data,
    packetizer_s2mm_v2_if.master m_axis_s2mm,
    input  logic [CNT_WIDTH-1:0] config_len,
    input  logic [PKT_WIDTH-1:0] config_npackets,
    output logic [CNT_WIDTH-1:0] counter,
    output logic [PKT_WIDTH-1:0] packet_count,
    output logic                 busy
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t                state_q;
    logic [CNT_WIDTH-1:0]  len_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [PKT_WIDTH-1:0]  np_q;
    logic [PKT_WIDTH-1:0]  pkt_q;
    logic                  m_valid_q;
    logic                  m_last_q;
    logic                  m_user_q;
    logic [DATA_WIDTH-1:0] m_data_q;

    logic                  s_ready_d;
    logic                  in_hs_d;
    logic                  beat_last_d;
    logic                  beat_user_d;
    logic [PKT_WIDTH-1:0]  pkt_inc_d;
    logic                  unused_in;

    // The input stream carries no framing of its own.
    assign unused_in = s_axis_data.tlast ^ s_axis_data.tuser;

    assign s_ready_d   = (state_q == ST_RUN) && (!m_valid_q || m_axis_s2mm.tready);
    assign in_hs_d     = s_axis_data.tvalid && s_ready_d;
    assign beat_user_d = (cnt_q == '0);
    assign beat_last_d = (cnt_q == len_q - CNT_WIDTH'(1));
    assign pkt_inc_d   = pkt_q + PKT_WIDTH'(1);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            np_q      <= '0;
            pkt_q     <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_user_q  <= 1'b0;
            m_data_q  <= '0;
        end else begin
            // Unload and load may coincide; the load wins so no beat is lost.
            if (m_valid_q && m_axis_s2mm.tready) begin
                m_valid_q <= 1'b0;
            end
            if (in_hs_d) begin
                m_valid_q <= 1'b1;
                m_data_q  <= s_axis_data.tdata;
                m_last_q  <= beat_last_d;
                m_user_q  <= beat_user_d;
            end

            case (state_q)
                ST_IDLE: begin
                    if (config_len != '0) begin
                        len_q   <= config_len;
                        np_q    <= config_npackets;
                        cnt_q   <= '0;
                        pkt_q   <= '0;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (in_hs_d) begin
                        if (beat_last_d) begin
                            cnt_q <= '0;
                            pkt_q <= pkt_inc_d;
                            if (np_q != '0 && pkt_inc_d == np_q) begin
                                state_q <= ST_DONE;
                            end else if (config_len == '0) begin
                                state_q <= ST_IDLE;
                            end else begin
                                len_q <= config_len;
                                np_q  <= config_npackets;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_WIDTH'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (config_len == '0) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign s_axis_data.tready = s_ready_d;
    assign m_axis_s2mm.tvalid = m_valid_q;
    assign m_axis_s2mm.tdata  = m_data_q;
    assign m_axis_s2mm.tlast  = m_last_q;
    assign m_axis_s2mm.tuser  = m_user_q;
    assign counter            = cnt_q;
    assign packet_count       = pkt_q;
    assign busy               = (state_q == ST_RUN);
endmodule

// File: tb/tb_packetizer_s2mm_v2.sv
// tb/tb_packetizer_s2mm_v2.sv - scoreboard bench for packetizer_s2mm_v2
module tb_packetizer_s2mm_v2;
    localparam int DW = 32;
    localparam int CW = 32;
    localparam int PW = 32;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [CW-1:0] config_len;
    logic [PW-1:0] config_npackets;
    logic [CW-1:0] counter;
    logic [PW-1:0] packet_count;
    logic          busy;

    packetizer_s2mm_v2_if #(.DATA_WIDTH(DW)) s_if();
    packetizer_s2mm_v2_if #(.DATA_WIDTH(DW)) m_if();

    packetizer_s2mm_v2 #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .PKT_WIDTH(PW)) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .s_axis_data     (s_if),
        .m_axis_s2mm     (m_if),
        .config_len      (config_len),
        .config_npackets (config_npackets),
        .counter         (counter),
        .packet_count    (packet_count),
        .busy            (busy)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic          user;
    } beat_t;

    int            total = 0;
    int            bad = 0;
    beat_t         exp_q[$];
    int            sink_mode = 0;
    int            mpos, mlen, mnp, mpkt;
    int            waits;
    logic [DW-1:0] data_ctr;

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Sink: 0 always ready, 1 random, 2 never ready.
    initial begin
        m_if.tready = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            case (sink_mode)
                0:       m_if.tready = 1'b1;
                1:       m_if.tready = 1'($urandom_range(0, 1));
                default: m_if.tready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every output handshake, checks stability while stalled.
    initial begin
        beat_t e;
        beat_t held;
        logic  stall_q;
        stall_q = 1'b0;
        held = '0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                stall_q = 1'b0;
            end else begin
                if (stall_q) begin
                    chk("stall_valid", m_if.tvalid, 1);
                    chk("stall_hold", {m_if.tdata, m_if.tlast, m_if.tuser}, held);
                end
                if (m_if.tvalid && m_if.tready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_beat: got data %0h expected no beat", m_if.tdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", m_if.tdata, e.data);
                        chk("out_last", m_if.tlast, e.last);
                        chk("out_user", m_if.tuser, e.user);
                    end
                end
                stall_q = m_if.tvalid && !m_if.tready;
                held = {m_if.tdata, m_if.tlast, m_if.tuser};
            end
        end
    end

    task automatic send(input int n);
        int guard;
        for (int i = 0; i < n; i++) begin
            beat_t b;
            s_if.tdata  = data_ctr;
            s_if.tvalid = 1'b1;
            guard = 0;
            @(negedge aclk);
            while (!s_if.tready && guard < 200) begin
                guard++;
                waits++;
                @(negedge aclk);
            end
            if (!s_if.tready) begin
                total++;
                bad++;
                $display("FAIL accept_timeout: beat %0d not accepted, required acceptance", i);
                s_if.tvalid = 1'b0;
                return;
            end
            b.data = data_ctr;
            b.user = (mpos == 0);
            b.last = (mpos == mlen - 1);
            exp_q.push_back(b);
            if (b.last) begin
                mpos = 0;
                mpkt++;
                if (!(mnp != 0 && mpkt == mnp)) begin
                    mlen = int'(config_len);
                    mnp  = int'(config_npackets);
                end
            end else begin
                mpos++;
            end
            data_ctr++;
            @(posedge aclk);
            #1;
            chk("counter", counter, mpos);
            chk("packet_count", packet_count, mpkt);
            chk("m_tvalid_after_accept", m_if.tvalid, 1);
        end
        s_if.tvalid = 1'b0;
    endtask

    task automatic start_run(input int len, input int np);
        config_len      = CW'(len);
        config_npackets = PW'(np);
        @(posedge aclk);
        #1;
        chk("busy_run", busy, 1);
        mpos = 0;
        mpkt = 0;
        mlen = len;
        mnp  = np;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 300) begin
            @(posedge aclk);
            #1;
            g++;
        end
        chk("drained_pending", exp_q.size(), 0);
    endtask

    task automatic do_reset(input int hold_len);
        aresetn    = 1'b0;
        config_len = CW'(hold_len);
        @(negedge aclk);
        chk("rst_m_tvalid", m_if.tvalid, 0);
        chk("rst_m_tlast", m_if.tlast, 0);
        chk("rst_counter", counter, 0);
        chk("rst_packet_count", packet_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_s_tready", s_if.tready, 0);
        exp_q.delete();
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        s_if.tdata = '0;
        s_if.tvalid = 1'b0;
        s_if.tlast = 1'b0;
        s_if.tuser = 1'b0;
        config_len = '0;
        config_npackets = '0;
        data_ctr = 32'h0000_1000;
        waits = 0;
        mpos = 0; mlen = 1; mnp = 0; mpkt = 0;
        do_reset(0);

        // 1: continuous full-rate packets of 10
        start_run(10, 0);
        waits = 0;
        send(30);
        chk("t1_full_rate_waits", waits, 0);
        drain();
        do_reset(0);

        // 2: random sink backpressure
        sink_mode = 1;
        start_run(10, 0);
        send(40);
        drain();
        sink_mode = 0;
        do_reset(0);

        // 3: one-shot of 3 packets of 4, then re-arm
        start_run(4, 3);
        send(12);
        s_if.tvalid = 1'b1;
        @(negedge aclk);
        chk("t3_done_tready", s_if.tready, 0);
        chk("t3_done_busy", busy, 0);
        chk("t3_done_pkts", packet_count, 3);
        s_if.tvalid = 1'b0;
        drain();
        config_len = '0;
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        chk("t3_idle_pkts_hold", packet_count, 3);
        chk("t3_idle_busy", busy, 0);
        start_run(4, 3);
        chk("t3_rearm_pkts", packet_count, 0);
        send(4);
        drain();
        do_reset(0);

        // 4: length change mid-packet applies at the boundary
        start_run(10, 0);
        send(3);
        config_len = CW'(5);
        send(7);
        chk("t4_first_pkt_done", packet_count, 1);
        send(10);
        chk("t4_short_pkts", packet_count, 3);
        drain();
        do_reset(0);

        // 5: single-beat packets
        start_run(1, 0);
        send(6);
        chk("t5_pkts", packet_count, 6);
        drain();
        do_reset(0);

        // 6: reset mid-packet with a beat stuck in the output register
        start_run(10, 0);
        send(15);
        drain();
        sink_mode = 2;
        send(1);
        chk("t6_counter_mid", counter, 6);
        do_reset(10);
        sink_mode = 0;
        start_run(10, 0);
        chk("t6_counter_fresh", counter, 0);
        send(20);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
